// File: rtl/ex_stage.sv
// ex_stage: execute stage with a combinational ALU and an optional 32-iteration shift-add signed multiplier.
// Define EX_MUL_EN to build the multiplier FSM for op 12; otherwise op 12 is undefined and o_stall is 0.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic [1:0]  i_WB,
  input  logic        i_M,
  input  logic [3:0]  i_ALUop,
  input  logic        i_ALUSrc,
  input  logic [31:0] i_BusA,
  input  logic [31:0] i_BusB,
  input  logic [31:0] i_imm32,
  input  logic [4:0]  i_shamt,
  input  logic [4:0]  i_Rw,
  output logic [1:0]  o_WB,
  output logic        o_M,
  output logic [4:0]  o_Rw,
  output logic        o_overflow,
  output logic [31:0] o_result,
  output logic [31:0] o_BusB,
  output logic        o_stall
);
  localparam logic [3:0] OP_MUL = 4'd12;

  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [31:0] mul_result;
  logic        alu_ovf;
  logic        mul_ovf;
  logic        mul_stall;
  logic        mul_done;

  always_comb begin
    op_b       = i_ALUSrc ? i_imm32 : i_BusB;
    alu_result = 32'd0;
    alu_ovf    = 1'b0;
    case (i_ALUop)
      4'd0: begin
        alu_result = i_BusA + op_b;
        alu_ovf    = (i_BusA[31] == op_b[31]) && (alu_result[31] != i_BusA[31]);
      end
      4'd1: begin
        alu_result = i_BusA - op_b;
        alu_ovf    = (i_BusA[31] != op_b[31]) && (alu_result[31] != i_BusA[31]);
      end
      4'd2:  alu_result = i_BusA & op_b;
      4'd3:  alu_result = i_BusA | op_b;
      4'd4:  alu_result = i_BusA ^ op_b;
      4'd5:  alu_result = ~(i_BusA | op_b);
      4'd6:  alu_result = {31'd0, $signed(i_BusA) < $signed(op_b)};
      4'd7:  alu_result = {31'd0, i_BusA < op_b};
      4'd8:  alu_result = op_b << i_shamt;
      4'd9:  alu_result = op_b >> i_shamt;
      4'd10: alu_result = $signed(op_b) >>> i_shamt;
      4'd11: alu_result = {op_b[15:0], 16'h0000};
      default: alu_result = 32'd0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] product;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;

  // Multiplies magnitudes; the sign is applied once the 32 iterations are done.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    mul_stall = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((i_ALUop == OP_MUL) && !i_flush) begin
          state_d   = BUSY;
          acc_d     = 64'd0;
          cnt_d     = 5'd0;
          mcand_d   = {32'd0, (i_BusA[31] ? (32'd0 - i_BusA) : i_BusA)};
          mplier_d  = op_b[31] ? (32'd0 - op_b) : op_b;
          sign_d    = i_BusA[31] ^ op_b[31];
          mul_stall = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          mul_stall = 1'b1;
          acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          cnt_d     = cnt_q + 5'd1;
          state_d   = (cnt_q == 5'd31) ? DONE : BUSY;
        end
      end
      DONE: begin
        state_d  = IDLE;
        mul_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    product    = sign_q ? (64'd0 - acc_q) : acc_q;
    mul_result = product[31:0];
    mul_ovf    = product[63:32] != {32{product[31]}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end
`else
  // Without the multiplier the stage is purely combinational, so clk has no consumer.
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    mul_stall  = 1'b0;
    mul_done   = 1'b0;
    mul_result = 32'd0;
    mul_ovf    = 1'b0;
  end
`endif

  always_comb begin
    o_WB       = 2'd0;
    o_M        = 1'b0;
    o_Rw       = 5'd0;
    o_overflow = 1'b0;
    o_result   = 32'd0;
    o_BusB     = i_BusB;
    o_stall    = 1'b0;
    if (!rst) begin
      o_BusB = 32'd0;
    end else if (i_flush || mul_stall) begin
      o_stall = mul_stall;
    end else if (mul_done) begin
      o_WB       = i_WB;
      o_M        = i_M;
      o_Rw       = i_Rw;
      o_overflow = mul_ovf;
      o_result   = mul_result;
    end else begin
      o_WB       = i_WB;
      o_M        = i_M;
      o_Rw       = i_Rw;
      o_overflow = alu_ovf;
      o_result   = alu_result;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven ALU vectors plus multiply, flush and reset sequences.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst, i_flush, i_M, i_ALUSrc;
  logic [1:0]  i_WB;
  logic [3:0]  i_ALUop;
  logic [31:0] i_BusA, i_BusB, i_imm32;
  logic [4:0]  i_shamt, i_Rw;
  logic [1:0]  o_WB;
  logic        o_M, o_overflow, o_stall;
  logic [4:0]  o_Rw;
  logic [31:0] o_result, o_BusB;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [31:0] a, b, imm;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_WB(i_WB), .i_M(i_M),
    .i_ALUop(i_ALUop), .i_ALUSrc(i_ALUSrc), .i_BusA(i_BusA), .i_BusB(i_BusB),
    .i_imm32(i_imm32), .i_shamt(i_shamt), .i_Rw(i_Rw),
    .o_WB(o_WB), .o_M(o_M), .o_Rw(o_Rw), .o_overflow(o_overflow),
    .o_result(o_result), .o_BusB(o_BusB), .o_stall(o_stall)
  );

  function automatic logic [73:0] pack_out();
    return {o_WB, o_M, o_Rw, o_overflow, o_result, o_BusB, o_stall};
  endfunction

  function automatic logic [73:0] exp_v(logic [1:0] wb, logic m, logic [4:0] rw, logic ovf,
                                        logic [31:0] res, logic [31:0] busb, logic st);
    return {wb, m, rw, ovf, res, busb, st};
  endfunction

  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] rw,
                       input logic [1:0] wb, input logic m);
    i_ALUop = op; i_ALUSrc = src; i_BusA = a; i_BusB = b; i_imm32 = imm;
    i_shamt = sh; i_Rw = rw; i_WB = wb; i_M = m;
  endtask

`ifdef EX_MUL_EN
  // Starts a multiply from IDLE, counts stall cycles and checks the DONE cycle outputs.
  task automatic run_mul(input string nm, input logic src, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rw, input logic [31:0] res,
                         input logic ovf);
    int   n;
    logic bub_ok;
    cyc();
    drive(4'd12, src, a, b, imm, 5'd0, rw, 2'b10, 1'b1);
    n = 0;
    bub_ok = 1'b1;
    smp();
    while (o_stall === 1'b1 && n < 40) begin
      n++;
      if (pack_out() !== exp_v(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, b, 1'b1)) bub_ok = 1'b0;
      smp();
    end
    chk({nm, " stall cycles"}, 74'(n), 74'd33);
    chk({nm, " bubbles"}, 74'(bub_ok), 74'd1);
    chk({nm, " result"}, pack_out(), exp_v(2'b10, 1'b1, rw, ovf, res, b, 1'b0));
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd0,  1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        5'd0,  32'h80000000, 1'b1};
    vecs[1]  = '{4'd1,  1'b0, 32'h00000005, 32'h00000007, 32'h0,        5'd0,  32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{4'd1,  1'b0, 32'h80000000, 32'h00000001, 32'h0,        5'd0,  32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{4'd0,  1'b1, 32'h00000002, 32'hDEADBEEF, 32'h3,        5'd0,  32'h00000005, 1'b0};
    vecs[4]  = '{4'd2,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd0,  32'hF000F000, 1'b0};
    vecs[5]  = '{4'd3,  1'b0, 32'h0F0F0000, 32'h000000FF, 32'h0,        5'd0,  32'h0F0F00FF, 1'b0};
    vecs[6]  = '{4'd4,  1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        5'd0,  32'hF0F00F0F, 1'b0};
    vecs[7]  = '{4'd5,  1'b0, 32'h0000FFFF, 32'h00FF0000, 32'h0,        5'd0,  32'hFF000000, 1'b0};
    vecs[8]  = '{4'd6,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd0,  32'h00000001, 1'b0};
    vecs[9]  = '{4'd7,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd0,  32'h00000000, 1'b0};
    vecs[10] = '{4'd8,  1'b1, 32'h00000000, 32'hDEADBEEF, 32'h1,        5'd31, 32'h80000000, 1'b0};
    vecs[11] = '{4'd9,  1'b0, 32'h00000000, 32'h80000010, 32'h0,        5'd4,  32'h08000001, 1'b0};
    vecs[12] = '{4'd10, 1'b0, 32'h00000000, 32'h80000010, 32'h0,        5'd4,  32'hF8000001, 1'b0};
    vecs[13] = '{4'd11, 1'b1, 32'h00000000, 32'h00000000, 32'hABCD1234, 5'd0,  32'h12340000, 1'b0};
    vecs[14] = '{4'd13, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd0,  32'h00000000, 1'b0};
    vecs[15] = '{4'd15, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        5'd0,  32'h00000000, 1'b0};
    vecs[16] = '{4'd0,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd0,  32'hFFFFFFFE, 1'b0};
    vecs[17] = '{4'd2,  1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        5'd0,  32'h00000001, 1'b0};

    rst = 1'b0;
    i_flush = 1'b0;
    drive(4'd0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0, 5'd9, 2'b11, 1'b1);
    smp();
    chk("reset outputs", pack_out(), 74'd0);
    cyc();
    cyc();
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc();
      drive(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].sh,
            5'(i + 1), 2'(i), 1'(i));
      smp();
      chk($sformatf("alu vec %0d", i), pack_out(),
          exp_v(2'(i), 1'(i), 5'(i + 1), vecs[i].ovf, vecs[i].res, vecs[i].b, 1'b0));
    end

`ifdef EX_MUL_EN
    run_mul("mul -3x7", 1'b0, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd17, 32'hFFFFFFEB, 1'b0);
    // Op still 12 in the cycle after DONE: a fresh multiply starts from IDLE.
    cyc();
    smp();
    chk("mul restart after done", pack_out(), exp_v(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd7, 1'b1));
    cyc();
    i_flush = 1'b1;
    smp();
    chk("flush busy1", pack_out(), exp_v(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd7, 1'b0));
    cyc();
    i_flush = 1'b0;
    drive(4'd0, 1'b0, 32'd2, 32'd3, 32'd0, 5'd0, 5'd4, 2'b01, 1'b0);
    smp();
    chk("add after flush busy1", pack_out(), exp_v(2'b01, 1'b0, 5'd4, 1'b0, 32'd5, 32'd3, 1'b0));

    run_mul("mul 2^16x2^16", 1'b0, 32'h00010000, 32'h00010000, 32'd0, 5'd3, 32'd0, 1'b1);
    run_mul("mul -1x-1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd5, 32'd1, 1'b0);
    run_mul("mul minint x 1", 1'b0, 32'h80000000, 32'd1, 32'd0, 5'd6, 32'h80000000, 1'b0);
    // Immediate operand -1 against the most negative value: +2^31 overflows.
    cyc();
    drive(4'd12, 1'b1, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 5'd0, 5'd7, 2'b11, 1'b0);
    i_flush = 1'b1;
    smp();
    chk("flush in idle on mul", pack_out(), exp_v(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h12345678, 1'b0));
    cyc();
    i_flush = 1'b0;
    drive(4'd4, 1'b0, 32'h0000000F, 32'h000000F0, 32'd0, 5'd0, 5'd8, 2'b11, 1'b1);
    smp();
    chk("no start after idle flush", pack_out(), exp_v(2'b11, 1'b1, 5'd8, 1'b0, 32'h000000FF, 32'h000000F0, 1'b0));
    run_mul("mul minint x imm -1", 1'b1, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 5'd9, 32'h80000000, 1'b1);

    cyc();
    drive(4'd12, 1'b0, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd0, 5'd10, 2'b10, 1'b1);
    for (int k = 1; k <= 10; k++) cyc();
    i_flush = 1'b1;
    smp();
    chk("flush busy10", pack_out(), exp_v(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd7, 1'b0));
    cyc();
    i_flush = 1'b0;
    drive(4'd0, 1'b0, 32'd2, 32'd3, 32'd0, 5'd0, 5'd6, 2'b01, 1'b1);
    smp();
    chk("add after flush busy10", pack_out(), exp_v(2'b01, 1'b1, 5'd6, 1'b0, 32'd5, 32'd3, 1'b0));

    cyc();
    drive(4'd12, 1'b0, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd0, 5'd11, 2'b10, 1'b1);
    for (int k = 1; k <= 20; k++) cyc();
    rst = 1'b0;
    smp();
    chk("reset busy20", pack_out(), 74'd0);
    cyc();
    rst = 1'b1;
    drive(4'd0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd0, 5'd12, 2'b01, 1'b0);
    smp();
    chk("idle after reset", pack_out(), exp_v(2'b01, 1'b0, 5'd12, 1'b0, 32'd2, 32'd1, 1'b0));
    run_mul("mul 6x7", 1'b0, 32'd6, 32'd7, 32'd0, 5'd13, 32'd42, 1'b0);
`else
    cyc();
    drive(4'd12, 1'b0, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd0, 5'd17, 2'b10, 1'b1);
    smp();
    chk("op12 undefined", pack_out(), exp_v(2'b10, 1'b1, 5'd17, 1'b0, 32'd0, 32'd7, 1'b0));
    cyc();
    smp();
    chk("op12 no stall", pack_out(), exp_v(2'b10, 1'b1, 5'd17, 1'b0, 32'd0, 32'd7, 1'b0));
    cyc();
    i_flush = 1'b1;
    drive(4'd0, 1'b0, 32'd2, 32'd3, 32'd0, 5'd0, 5'd6, 2'b01, 1'b1);
    smp();
    chk("flush bubble", pack_out(), exp_v(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd3, 1'b0));
    cyc();
    i_flush = 1'b0;
    smp();
    chk("add after flush", pack_out(), exp_v(2'b01, 1'b1, 5'd6, 1'b0, 32'd5, 32'd3, 1'b0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline, sitting directly upstream of the EX/MEM pipeline register and driving its `WB`, `M`, `overflow`, `result`, `BusB` and `Rw` inputs. It performs all single-cycle ALU operations combinationally. It also runs an optional 32-iteration shift-add signed multiplier that stalls the front of the pipeline and emits bubbles until the product is ready.

## Interface
- No parameters; datapath is fixed at 32 bits.
- `clk` in 1: pipeline clock; the FSM updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `i_flush` in 1: kill the instruction currently in EX; aborts a multiply.
- `i_WB` in 2: write-back controls, passed through.
- `i_M` in 1: memory control, passed through.
- `i_ALUop` in 4: operation select.
- `i_ALUSrc` in 1: operand B select; 1 = `i_imm32`, 0 = `i_BusB`.
- `i_BusA` in 32: operand A.
- `i_BusB` in 32: register operand B and store data.
- `i_imm32` in 32: extended immediate.
- `i_shamt` in 5: shift amount.
- `i_Rw` in 5: destination register.
- `o_WB` out 2, `o_M` out 1, `o_Rw` out 5: controls to EX/MEM.
- `o_overflow` out 1: signed overflow.
- `o_result` out 32: ALU or multiplier result.
- `o_BusB` out 32: store data, equal to `i_BusB`.
- `o_stall` out 1: freeze PC and IF/ID/ID-EX; upstream inputs must stay stable while high.

## Operation
- B = `i_ALUSrc` ? `i_imm32` : `i_BusB`.
- `i_ALUop` encoding:
  - 0 ADD, 1 SUB: overflow = signed overflow of the 32-bit result.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU: result 1 or 0.
  - 8 SLL, 9 SRL, 10 SRA: operate on B by `i_shamt`.
  - 11 LUI: {B[15:0], 16'h0}.
  - 12 MUL.
  - 13–15: undefined; result 0, overflow 0.
- `o_overflow` is 0 for every op other than ADD, SUB and MUL.
- Bubble means all of the following: `o_WB` = 0, `o_M` = 0, `o_Rw` = 0, `o_overflow` = 0, `o_result` = 0. `o_BusB` still follows `i_BusB`.
- `i_flush` high forces a bubble that cycle. The FSM goes to IDLE and `o_stall` drops to 0.
- While `rst` is low, all outputs are 0.
- MUL FSM, states IDLE / BUSY / DONE:
  - IDLE, op = 12 and no flush: latch |A|, |B| and the result sign (A[31]^B[31]); clear the 64-bit accumulator and the 5-bit counter. `o_stall` = 1 combinationally, output is a bubble. Next state BUSY.
  - BUSY: each cycle, add the multiplicand if the multiplier LSB is 1, then shift, and increment the counter. `o_stall` = 1, output is a bubble. After the iteration with counter = 31, go to DONE.
  - DONE: `o_stall` = 0. `o_result` = low 32 bits of the signed product (negated if the sign flag is set). `o_overflow` = 1 iff the 64-bit signed product ≠ sign-extension of its low 32 bits. `o_WB`, `o_M` and `o_Rw` come from the inputs. Next state is always IDLE, even if `i_ALUop` still reads 12 that cycle.
- Operands are latched at start. Input changes during BUSY are ignored except `i_flush` and `rst`.
- Counter wrap 31→0 is never used; leaving BUSY is decided by counter == 31.
- A MUL arriving the cycle after DONE starts a fresh multiply from IDLE.

## Timing
- Non-MUL ops: zero latency, combinational from inputs to outputs. `o_stall` = 0.
- MUL: `o_stall` is high for 33 consecutive cycles (the IDLE start cycle plus 32 BUSY cycles). The result is valid in the 34th cycle, DONE.
- EX/MEM therefore captures 33 bubbles followed by one MUL result.
- Flush during BUSY: bubble and `o_stall` = 0 in the same cycle; IDLE on the next edge.
- `rst` low during BUSY: IDLE on the next edge, accumulator cleared.
- Flush and `rst` together: reset wins; both yield IDLE.

## Configuration
- `EX_MUL_EN` defined: MUL FSM and accumulator are built and op 12 behaves as above.
- `EX_MUL_EN` undefined: no FSM. Op 12 is undefined (result 0, overflow 0). `o_stall` is tied to 0.

## Test plan
- ADD: A=32'h7FFFFFFF, B=1, `i_ALUSrc`=0 -> result 32'h80000000, overflow 1. SUB: A=5, B=7 -> 32'hFFFFFFFE, overflow 0.
- SRA: B=32'h80000010, `i_shamt`=4 -> 32'hF8000001. SLT with A=-1, B=1 -> 1. SLTU with the same operands -> 0.
- MUL: A=-3, B=7 -> `o_stall` high for exactly 33 cycles with bubbles, then result 32'hFFFFFFEB, overflow 0, `o_Rw` = `i_Rw`. Cycle 35 is back in IDLE.
- MUL: A=32'h00010000, B=32'h00010000 -> result 0, overflow 1. MUL with A=-1, B=-1 -> result 1, overflow 0.
- `i_flush` asserted at BUSY cycle 10 -> immediate bubble and `o_stall` = 0. A following ADD 2+3 -> 5 with no stall.
- `rst` low for one cycle at BUSY cycle 20 -> all outputs 0. Afterwards a new MUL 6×7 takes the full 33 stall cycles and gives 42.
